// File: rtl/data_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : data_stream_arbiter
// Description : Round-robin burst arbiter that merges N_CH first-word-fall-
//               through word sources into one 32-bit output stream. A source
//               keeps the grant for up to MAX_BURST words. One IDLE cycle
//               separates consecutive grants. Downstream throttling
//               (FIFO_NEAR_FULL) and per-word backpressure (ARB_READY_OUT)
//               are supported.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Optional feature macro: ARB_WORD_COUNT_EN
//    defined   -> per-source 16-bit saturating word counters on WORD_CNT,
//                 cleared by CNT_CLR (clear beats a simultaneous increment)
//    undefined -> WORD_CNT tied to 0, CNT_CLR ignored, no counter flops
// ----------------------------------------------------------------------------
// Ports
//    BUS_CLK         in   1         clock
//    BUS_RSTB        in   1         asynchronous active-low reset
//    ENABLE          in   1         arbitration enable
//    WRITE_IN        in   N_CH      per-source word-available flag (FWFT)
//    DATA_IN         in   32*N_CH   per-source word, source i at [32i+31:32i]
//    READY_OUT       out  N_CH      per-source pop strobe, one per word taken
//    ARB_WRITE_OUT   out  1         output word valid
//    ARB_DATA_OUT    out  32        output word
//    ARB_READY_OUT   in   1         downstream pop of the output word
//    FIFO_NEAR_FULL  in   1         downstream throttle, blocks loads
//    CNT_CLR         in   1         synchronous clear of word counters
//    WORD_CNT        out  16*N_CH   per-source transferred-word counters
// ============================================================================
module data_stream_arbiter #(
   parameter int N_CH      = 4,
   parameter int MAX_BURST = 16
) (
   input  logic                 BUS_CLK,
   input  logic                 BUS_RSTB,
   input  logic                 ENABLE,
   input  logic [N_CH-1:0]      WRITE_IN,
   input  logic [32*N_CH-1:0]   DATA_IN,
   output logic [N_CH-1:0]      READY_OUT,
   output logic                 ARB_WRITE_OUT,
   output logic [31:0]          ARB_DATA_OUT,
   input  logic                 ARB_READY_OUT,
   input  logic                 FIFO_NEAR_FULL,
   input  logic                 CNT_CLR,
   output logic [16*N_CH-1:0]   WORD_CNT
);

   localparam int              GW          = $clog2(N_CH);
   localparam int              BW          = 8;
   localparam logic [BW-1:0]   LAST_LOAD   = BW'(MAX_BURST - 1);
   localparam logic [GW-1:0]   LAST_SRC    = GW'(N_CH - 1);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } state_e;

   state_e          state_q;
   logic [GW-1:0]   grant_q;
   logic [GW-1:0]   ptr_q;
   logic [BW-1:0]   burst_cnt_q;
   logic            out_vld_q;
   logic [31:0]     out_data_q;

   logic [GW-1:0]   w_first_req;
   logic [GW-1:0]   w_cand;
   logic [GW-1:0]   w_next_ptr;
   logic [31:0]     w_sel_data;
   logic            w_load;
   logic            w_burst_end;

   // First requesting source at or after the round-robin pointer. The loop
   // runs from the farthest candidate down so the nearest one wins.
   always_comb begin
      w_first_req = ptr_q;
      w_cand      = '0;
      for (int k = N_CH - 1; k >= 0; k--) begin
         w_cand = GW'((int'(ptr_q) + k) % N_CH);
         if (WRITE_IN[w_cand]) begin
            w_first_req = w_cand;
         end
      end
   end

   assign w_sel_data = DATA_IN[{grant_q, 5'b0} +: 32];
   assign w_next_ptr = (grant_q == LAST_SRC) ? '0 : grant_q + 1'b1;

   // A word moves only when the output stage is free or being popped in the
   // same cycle, so a full stage under backpressure never gets overwritten.
   assign w_load = (state_q == ST_BURST) && WRITE_IN[grant_q] &&
                   !FIFO_NEAR_FULL && (!out_vld_q || ARB_READY_OUT);

   // Throttling alone never ends a burst; only a dry source, the burst
   // limit or disabling does.
   assign w_burst_end = (state_q == ST_BURST) &&
                        (!ENABLE || !WRITE_IN[grant_q] ||
                         (w_load && (burst_cnt_q == LAST_LOAD)));

   assign READY_OUT     = w_load ? (N_CH'(1) << grant_q) : '0;
   assign ARB_WRITE_OUT = out_vld_q;
   assign ARB_DATA_OUT  = out_data_q;

   always_ff @(posedge BUS_CLK or negedge BUS_RSTB) begin
      if (!BUS_RSTB) begin
         state_q     <= ST_IDLE;
         grant_q     <= '0;
         ptr_q       <= '0;
         burst_cnt_q <= '0;
         out_vld_q   <= 1'b0;
         out_data_q  <= '0;
      end else begin
         // Output stage: a load at the pop edge keeps the stage valid.
         if (w_load) begin
            out_vld_q  <= 1'b1;
            out_data_q <= w_sel_data;
         end else if (ARB_READY_OUT) begin
            out_vld_q  <= 1'b0;
         end

         case (state_q)
            ST_IDLE: begin
               if (ENABLE && (|WRITE_IN)) begin
                  grant_q     <= w_first_req;
                  burst_cnt_q <= '0;
                  state_q     <= ST_BURST;
               end
            end
            ST_BURST: begin
               if (w_load) begin
                  burst_cnt_q <= burst_cnt_q + 1'b1;
               end
               if (w_burst_end) begin
                  state_q <= ST_IDLE;
                  ptr_q   <= w_next_ptr;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef ARB_WORD_COUNT_EN
   generate
      for (genvar i = 0; i < N_CH; i++) begin : g_word_cnt
         logic [15:0] cnt_q;
         logic [15:0] cnt_d;

         always_comb begin
            cnt_d = cnt_q;
            if (CNT_CLR) begin
               cnt_d = '0;
            end else if (READY_OUT[i] && (cnt_q != 16'hFFFF)) begin
               cnt_d = cnt_q + 16'd1;
            end
         end

         always_ff @(posedge BUS_CLK or negedge BUS_RSTB) begin
            if (!BUS_RSTB) begin
               cnt_q <= '0;
            end else begin
               cnt_q <= cnt_d;
            end
         end

         assign WORD_CNT[16*i +: 16] = cnt_q;
      end
   endgenerate
`else
   assign WORD_CNT = '0;

   logic w_unused_cnt_clr;
   assign w_unused_cnt_clr = CNT_CLR;
`endif

endmodule
`default_nettype wire
